// File: rtl/bip_debug_unit_if.sv
// Signal bundle between bip_debug_unit, the UART (rx/tx) and the BIP core.
// The master modport is the debug unit side and the slave modport is the environment side.
interface bip_debug_unit_if #(
  parameter int PC_WIDTH  = 11,
  parameter int ACC_WIDTH = 16
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 bip_en;
  logic                 bip_reset;
  logic                 bip_halt;
  logic [PC_WIDTH-1:0]  bip_pc;
  logic [ACC_WIDTH-1:0] bip_acc;

  modport master (
    input  rx_data, rx_valid, tx_busy, bip_halt, bip_pc, bip_acc,
    output tx_data, tx_start, bip_en, bip_reset
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, bip_halt, bip_pc, bip_acc,
    input  tx_data, tx_start, bip_en, bip_reset
  );
endinterface

// File: rtl/bip_debug_unit.sv
// Debug/control unit: decodes UART commands, gates the BIP clock enable or resets it,
// and streams a 6-byte PC/ACC/cycle-count dump to the UART transmitter after each run or step.
module bip_debug_unit #(
  parameter int PC_WIDTH  = 11,
  parameter int ACC_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  bip_debug_unit_if.master  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_STEP    = 3'd2;
  localparam logic [2:0] S_SNAP    = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;
  localparam logic [2:0] S_WAIT_LO = 3'd6;
  localparam logic [2:0] S_BRST    = 3'd7;

  localparam logic [7:0] CMD_RUN   = 8'h63;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_RESET = 8'h72;
  localparam logic [2:0] LAST_IDX  = 3'd5;

  logic [2:0]  r_state;
  logic [2:0]  r_idx;
  logic        r_brst_cnt;
  logic [15:0] r_cnt;
  logic [47:0] r_snap;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;

  logic [2:0]  w_next_state;
  logic        w_bip_en;
  logic        w_bip_reset;
  logic [47:0] w_live;

  // Dump order: PC hi/lo, ACC hi/lo, CNT hi/lo.
  function automatic logic [7:0] f_dump_byte(input logic [47:0] snap, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = snap[47:40];
      3'd1:    b = snap[39:32];
      3'd2:    b = snap[31:24];
      3'd3:    b = snap[23:16];
      3'd4:    b = snap[15:8];
      3'd5:    b = snap[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign w_live = {16'(bus.bip_pc), 16'(bus.bip_acc), r_cnt};

  // BIP control: the run enable drops in the same cycle the halt flag is seen.
  always_comb begin
    w_bip_en    = 1'b0;
    w_bip_reset = 1'b0;
    if (r_state == S_RUN) begin
      w_bip_en = ~bus.bip_halt;
    end else if (r_state == S_STEP) begin
      w_bip_en = 1'b1;
    end else if (r_state == S_BRST) begin
      w_bip_reset = 1'b1;
    end else begin
      w_bip_en    = 1'b0;
      w_bip_reset = 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_RUN:   w_next_state = bus.bip_halt ? S_SNAP : S_RUN;
            CMD_STEP:  w_next_state = bus.bip_halt ? S_SNAP : S_STEP;
            CMD_RESET: w_next_state = S_BRST;
            default:   w_next_state = S_IDLE;
          endcase
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN:     w_next_state = bus.bip_halt ? S_SNAP : S_RUN;
      S_STEP:    w_next_state = S_SNAP;
      S_SNAP:    w_next_state = S_SEND;
      S_SEND:    w_next_state = S_WAIT_HI;
      S_WAIT_HI: w_next_state = bus.tx_busy ? S_WAIT_LO : S_WAIT_HI;
      S_WAIT_LO: begin
        if (bus.tx_busy) begin
          w_next_state = S_WAIT_LO;
        end else if (r_idx == LAST_IDX) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_SEND;
        end
      end
      S_BRST:    w_next_state = r_brst_cnt ? S_IDLE : S_BRST;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State, snapshot and transmit registers; tx_start is raised on the edge entering SEND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_brst_cnt <= 1'b0;
      r_snap     <= 48'd0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_tx_start <= 1'b0;
      case (r_state)
        S_SNAP: begin
          r_snap     <= w_live;
          r_idx      <= 3'd0;
          r_tx_data  <= f_dump_byte(w_live, 3'd0);
          r_tx_start <= 1'b1;
        end
        S_WAIT_LO: begin
          if (!bus.tx_busy && (r_idx != LAST_IDX)) begin
            r_idx      <= r_idx + 3'd1;
            r_tx_data  <= f_dump_byte(r_snap, r_idx + 3'd1);
            r_tx_start <= 1'b1;
          end
        end
        S_BRST:  r_brst_cnt <= ~r_brst_cnt;
        default: r_brst_cnt <= 1'b0;
      endcase
    end
  end

  // Saturating count of enabled BIP cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 16'd0;
    end else if (r_state == S_BRST) begin
      r_cnt <= 16'd0;
    end else if (w_bip_en && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign bus.tx_data   = r_tx_data;
  assign bus.tx_start  = r_tx_start;
  assign bus.bip_en    = w_bip_en;
  assign bus.bip_reset = w_bip_reset;

endmodule

// File: tb/tb_bip_debug_unit.sv
// Directed bench for bip_debug_unit with a behavioural BIP halt model and a UART tx model.
module tb_bip_debug_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bip_debug_unit_if #(.PC_WIDTH(11), .ACC_WIDTH(16)) bus ();

  bip_debug_unit #(.PC_WIDTH(11), .ACC_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // BIP model: halts after halt_at enabled cycles since its last reset (0 = never).
  logic tb_halt = 1'b0;
  int   en_total = 0;
  int   halt_at = 0;
  always @(posedge clk) begin
    if (bus.bip_reset) begin
      tb_halt  <= 1'b0;
      en_total <= 0;
    end else if (bus.bip_en) begin
      en_total <= en_total + 1;
      if (halt_at != 0 && en_total + 1 == halt_at) tb_halt <= 1'b1;
    end
  end
  assign bus.bip_halt = tb_halt;

  // UART tx model: logs each requested byte, busy for 4 cycles starting the next cycle.
  logic       tb_busy = 1'b0;
  int         bcnt = 0;
  logic [7:0] tx_log [0:255];
  int         tx_n = 0;
  int         en_cycles = 0;
  int         rst_cycles = 0;
  always @(posedge clk) begin
    if (bus.tx_start) begin
      tx_log[tx_n[7:0]] <= bus.tx_data;
      tx_n    <= tx_n + 1;
      tb_busy <= 1'b1;
      bcnt    <= 4;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) tb_busy <= 1'b0;
    end
    if (bus.bip_en)    en_cycles  <= en_cycles + 1;
    if (bus.bip_reset) rst_cycles <= rst_cycles + 1;
  end
  assign bus.tx_busy = tb_busy;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int limit, input string name);
    int k;
    k = 0;
    while (tx_n < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (tx_n < target) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got %0d bytes required %0d", name, tx_n, target);
    end
  endtask

  task automatic check_dump(input string name, input int start, input logic [47:0] exp);
    logic [47:0] e;
    e = exp;
    for (int b = 0; b < 6; b++)
      check($sformatf("%s byte%0d", name, b), 64'(tx_log[start + b]), 64'(e[47 - 8*b -: 8]));
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [10:0] pc;
    logic [15:0] acc;
    int          halt_at;
    int          exp_en;
    int          exp_rst;
    int          exp_tx;
    logic [47:0] exp_dump;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int s_tx, s_en, s_rst;

    vecs[0] = '{8'h73, 11'h003, 16'h1234, 0,  1,  0, 6, 48'h0003_1234_0001};
    vecs[1] = '{8'h72, 11'h003, 16'h1234, 0,  0,  2, 0, 48'h0};
    vecs[2] = '{8'h63, 11'h00A, 16'hFFFE, 10, 10, 0, 6, 48'h000A_FFFE_000A};
    vecs[3] = '{8'h63, 11'h00A, 16'hFFFE, 10, 0,  0, 6, 48'h000A_FFFE_000A};
    vecs[4] = '{8'h72, 11'h00A, 16'hFFFE, 0,  0,  2, 0, 48'h0};
    vecs[5] = '{8'h73, 11'h00B, 16'h0001, 0,  1,  0, 6, 48'h000B_0001_0001};
    vecs[6] = '{8'h41, 11'h00B, 16'h0001, 0,  0,  0, 0, 48'h0};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.bip_pc   = 11'h000;
    bus.bip_acc  = 16'h0000;

    // Reset values, then 100 idle cycles.
    repeat (3) @(negedge clk);
    check("rst tx_start", 64'(bus.tx_start), 64'd0);
    check("rst tx_data", 64'(bus.tx_data), 64'h00);
    check("rst bip_en", 64'(bus.bip_en), 64'd0);
    check("rst bip_reset", 64'(bus.bip_reset), 64'd0);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("idle en cycles", 64'(en_cycles), 64'd0);
    check("idle tx count", 64'(tx_n), 64'd0);
    check("idle bip_reset", 64'(bus.bip_reset), 64'd0);

    for (int i = 0; i < 7; i++) begin
      bus.bip_pc  = vecs[i].pc;
      bus.bip_acc = vecs[i].acc;
      halt_at     = vecs[i].halt_at;
      s_tx = tx_n; s_en = en_cycles; s_rst = rst_cycles;
      send_cmd(vecs[i].cmd);
      if (vecs[i].exp_tx != 0) wait_tx(s_tx + vecs[i].exp_tx, 2000, $sformatf("v%0d", i));
      repeat (20) @(negedge clk);
      check($sformatf("v%0d en cycles", i), 64'(en_cycles - s_en), 64'(vecs[i].exp_en));
      check($sformatf("v%0d rst cycles", i), 64'(rst_cycles - s_rst), 64'(vecs[i].exp_rst));
      check($sformatf("v%0d tx count", i), 64'(tx_n - s_tx), 64'(vecs[i].exp_tx));
      if (vecs[i].exp_tx != 0) check_dump($sformatf("v%0d", i), s_tx, vecs[i].exp_dump);
    end

    // Step latency, and bytes arriving during the dump are dropped.
    s_tx = tx_n; s_en = en_cycles;
    send_cmd(8'h73);
    check("step en N+1", 64'(bus.bip_en), 64'd1);
    @(negedge clk);
    check("step en N+2", 64'(bus.bip_en), 64'd0);
    check("step snap tx_start", 64'(bus.tx_start), 64'd0);
    @(negedge clk);
    check("step tx_start N+3", 64'(bus.tx_start), 64'd1);
    check("step tx_data N+3", 64'(bus.tx_data), 64'h00);
    repeat (3) @(negedge clk);
    send_cmd(8'h41);
    repeat (5) @(negedge clk);
    send_cmd(8'h73);
    wait_tx(s_tx + 6, 2000, "ignore");
    repeat (50) @(negedge clk);
    check("ignore tx count", 64'(tx_n - s_tx), 64'd6);
    check("ignore en cycles", 64'(en_cycles - s_en), 64'd1);
    check_dump("ignore", s_tx, 48'h000B_0001_0002);

    // Counter saturation over a long run.
    send_cmd(8'h72);
    repeat (5) @(negedge clk);
    bus.bip_pc = 11'h7FF; bus.bip_acc = 16'h0000; halt_at = 70000;
    s_tx = tx_n; s_en = en_cycles;
    send_cmd(8'h63);
    wait_tx(s_tx + 6, 75000, "sat");
    repeat (20) @(negedge clk);
    check("sat en cycles", 64'(en_cycles - s_en), 64'd70000);
    check_dump("sat", s_tx, 48'h07FF_0000_FFFF);

    // Reset during the third dump byte aborts the dump.
    s_tx = tx_n;
    send_cmd(8'h63);
    wait_tx(s_tx + 3, 2000, "abort");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort tx_start", 64'(bus.tx_start), 64'd0);
    check("abort tx_data", 64'(bus.tx_data), 64'h00);
    check("abort bip_en", 64'(bus.bip_en), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("abort tx count", 64'(tx_n - s_tx), 64'd3);
    s_tx = tx_n; s_en = en_cycles;
    send_cmd(8'h73);
    wait_tx(s_tx + 6, 2000, "post abort");
    repeat (20) @(negedge clk);
    check("post abort en", 64'(en_cycles - s_en), 64'd0);
    check_dump("post abort", s_tx, 48'h07FF_0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
